mmio_tx_port: RTL
=================

Name: mmio_tx_port

Overview:
- Memory-mapped serial transmit peripheral on the processor's data-memory write bus (MemWrite, DataAdr, WriteData).
- It is the responder side of that bus: it accepts CPU stores to its data address and queues the low byte in a FIFO.
- It serialises each queued byte as an 8N1 frame on tx.
- It returns a status word on ReadData for loads from its status address.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit (>=2).
- DEPTH, 8, FIFO entries (power of 2, >=2).
- TX_DATA_ADDR, 32'hFFFF_0000, store target for transmit bytes.
- STATUS_ADDR, 32'hFFFF_0004, load/store target for status.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  CPU store strobe, one cycle per store.
- DataAdr  in  32  CPU data address.
- WriteData  in  32  CPU store data.
- ReadData  out  32  status word when DataAdr==STATUS_ADDR, else 0; combinational.
- tx  out  1  serial line, idle high.
- irq  out  1  registered; high while FIFO empty and serializer idle.

Behaviour:
- Reset (sampled at rising clk when reset=1): FIFO emptied, overflow cleared, FSM to IDLE, bit counters 0. After that edge: tx=1, irq=1, ReadData status = 32'h0000_0001 when addressed.
- Reset mid-frame aborts the frame: tx=1 from the following cycle; queued bytes are discarded.
- Push:
  - Condition: MemWrite && DataAdr==TX_DATA_ADDR at a rising edge.
  - Pushes WriteData[7:0]; WriteData[31:8] is ignored.
  - Accepted iff count<DEPTH or a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set (sticky).
- Status store: MemWrite && DataAdr==STATUS_ADDR with WriteData[2]=1 clears overflow. If an overflow event occurs on the same edge, overflow stays set.
- Other addresses are ignored entirely.
- Status word layout:
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow
  - bit3 = busy (FSM != IDLE)
  - bits[11:8] = count (width clog2(DEPTH)+1, zero-extended)
  - all other bits 0
- FSM states IDLE, START, DATA, STOP; register bit timer (0..CLKS_PER_BIT-1), bit index (0..7), shift register.
- IDLE: tx=1. If FIFO non-empty: pop the head into the shift register, go to START with timer=0.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with index=0.
- DATA: tx=shift[0] (LSB first). Each CLKS_PER_BIT cycles shift right and increment index; after index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At expiry:
  - if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap);
  - else go to IDLE.
- Latency: store at edge N into an empty, idle block → pop at edge N+1 → tx=0 during cycles after edges N+1..N+CLKS_PER_BIT. Frame length is 10*CLKS_PER_BIT cycles.
- tx is driven from a register (glitch-free).
- Count arithmetic: push and pop on the same edge leave count unchanged. Read and write pointers wrap modulo DEPTH.
- irq is registered: irq(next) = (count_next==0) && (state_next==IDLE).

Decomposition:
- Shared package mmio_tx_pkg holds:
  - the FSM state enum (tx_state_t: IDLE, START, DATA, STOP);
  - status bit-index constants (ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_BUSY=3, ST_COUNT_LSB=8);
  - default address constants.
- One sub-module: sync_fifo, parameterised on WIDTH and DEPTH.
  - Inputs: push, pop.
  - Outputs: head, empty, full, count.
  - Synchronous reset.
  - Push when full is ignored internally unless pop is asserted on the same edge.
- Top level holds the address decode, overflow flag, FSM/serializer and irq register.

Test Plan:
- Reset then idle 10 cycles → tx=1, irq=1, status load reads 32'h0000_0001.
- Store 32'h1234_56A5 to TX_DATA_ADDR with CLKS_PER_BIT=4 → tx low 4 cycles starting 1 cycle after the store edge, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. irq=0 during the frame and returns to 1 after 40 cycles.
- Three back-to-back stores 8'h01, 8'h80, 8'hFF → three contiguous 40-cycle frames with no idle gap. Status count reads 2 after the first pop.
- Nine stores with no gaps while idle (DEPTH=8): the first store is popped, 8 bytes are queued, and count/full are correct. A 10th store while full with no pop → byte dropped, status bit2=1. Store 32'h4 to STATUS_ADDR → bit2 clears. Exactly 9 frames are transmitted.
- Store a byte to an unrelated address (32'h0000_0064) → no push, tx stays 1, ReadData=0 for that address.
- Assert reset for 1 cycle midway through the DATA bits of a frame with 3 bytes queued → tx=1 from the next cycle, status=32'h0000_0001, no further frames transmitted.

Source files
------------

// File: rtl/mmio_tx_pkg.sv
// Shared types and constants for the memory-mapped serial transmit port.
// Holds the serializer state encoding, status bit positions and default addresses.
package mmio_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_BUSY      = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int DEF_DEPTH        = 8;

    localparam logic [31:0] DEF_TX_DATA_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] DEF_STATUS_ADDR  = 32'hFFFF_0004;

endpackage

// File: rtl/mmio_tx_port_sync_fifo.sv
// Synchronous FIFO with occupancy count, used as the transmit byte queue.
// A push while full only lands when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_tx_port.sv
// Memory-mapped 8N1 transmit port: stores queue bytes, a serializer drains them.
// Status loads report empty/full/overflow/busy and the queue occupancy.
module mmio_tx_port
    import mmio_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int          DEPTH        = DEF_DEPTH,
    parameter logic [31:0] TX_DATA_ADDR = DEF_TX_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    tx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;

    logic          push_req;
    logic          stat_wr;
    logic          pop;
    logic          push_ok;
    logic          ovf_ev;
    logic          tmr_end;
    logic [7:0]    fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;
    logic [31:0]   status;
    logic          unused_wdata;

    assign push_req     = MemWrite && (DataAdr == TX_DATA_ADDR);
    assign stat_wr      = MemWrite && (DataAdr == STATUS_ADDR);
    assign push_ok      = push_req && (!fifo_full || pop);
    assign ovf_ev       = push_req && fifo_full && !pop;
    assign tmr_end      = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign unused_wdata = ^WriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (WriteData[7:0]),
        .pop   (pop),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Serializer next state; pops the queue head when starting a frame.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tmr_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (tmr_end) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (tmr_end) begin
                    timer_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered line level and interrupt, derived from the next state.
    always_comb begin
        count_nxt = fifo_count;
        unique case ({push_ok, pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        irq_d = (count_nxt == '0) && (state_d == IDLE);
    end

    // Sticky overflow; a drop on the same edge wins over a clear.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_wr && WriteData[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (ovf_ev) begin
            ovf_d = 1'b1;
        end
    end

    // Status word assembly and load decode.
    always_comb begin
        status                         = '0;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_FULL]                = fifo_full;
        status[ST_OVF]                 = ovf_q;
        status[ST_BUSY]                = (state_q != IDLE);
        status[ST_COUNT_LSB +: CW]     = fifo_count;
        ReadData = (DataAdr == STATUS_ADDR) ? status : 32'h0;
    end

    // State registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx  = tx_q;
    assign irq = irq_q;

endmodule
